gbe64_tx_packet_ctrl: RTL and testbench
=======================================

// Module: gbe64_tx_packet_ctrl
// PURPOSE
//  Sequences the photon word stream into the 64-bit 10GbE TX core. Frames each packet as
//  one header word, then up to pkt_words payload words, then end-of-frame. Flushes partial
//  packets on input timeout and throttles on TX almost-full. Counts TX overrun events;
//  tx_overrun_cnt drives user_data_in of the gbe64_tx_overrun software register.
// PARAMETERS
//  DATA_W     64    payload/TX word width
//  MAX_WORDS  100   upper limit on payload words per packet (1..255)
//  TIMEOUT    1024  idle cycles inside PAY before a partial packet is flushed (>=2)
//  CNT_W      32    width of sequence, packet and overrun counters
// PORTS
//  user_clk        in   1       sole clock; all logic is on its rising edge
//  user_rst        in   1       synchronous, active-high reset
//  enable          in   1       high: new packets may start
//  pkt_words       in   8       payload words per packet; 0 -> MAX_WORDS; >MAX_WORDS -> MAX_WORDS
//  in_data         in   DATA_W  photon word
//  in_valid        in   1       in_data valid
//  in_ready        out  1       word accepted when in_valid & in_ready
//  tx_data         out  DATA_W  word to the TX core
//  tx_valid        out  1       tx_data valid this cycle
//  tx_end_of_frame out  1       last word of the frame (qualified by tx_valid)
//  tx_afull        in   1       TX core FIFO almost full
//  tx_overflow     in   1       TX core overflow pulse/level
//  tx_overrun_cnt  out  CNT_W   cycles with tx_overflow high, saturating
//  pkt_cnt         out  CNT_W   frames completed (EOF emitted), wraps
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. tx_valid, tx_end_of_frame, in_ready and busy = 0. tx_data = 0.
//    seq, pkt_cnt, tx_overrun_cnt and ts = 0. Reset mid-packet abandons the frame; no EOF.
//  - ts: free-running CNT_W counter; wraps.
//  - FSM:
//    IDLE: go to HDR when enable & in_valid & !tx_afull.
//    HDR:  emit one word {seq[31:0], ts[31:0]} with tx_valid=1 and EOF=0.
//          Latch the effective length L from pkt_words. seq increments (wraps). Go to PAY.
//    PAY:  in_ready = !tx_afull. Each accepted word is emitted on tx_data the next cycle.
//          The word accepted with wcnt==L-1 carries EOF; then go to IDLE and increment pkt_cnt.
//          Timeout counter: counts cycles with in_ready & !in_valid, clears on accept, and
//          holds while tx_afull. When it reaches TIMEOUT-1, emit pad word {DATA_W{1'b1}} with
//          EOF, go to IDLE, increment pkt_cnt. Timeout and accept in the same cycle: accept wins.
//  - in_ready is 0 in IDLE and HDR. It is a combinational function of the registered state
//    and tx_afull. Latency from accept to tx_valid is 1 cycle. tx_* outputs are registered.
//  - tx_afull asserted in IDLE: the packet does not start. Asserted in PAY: no new accepts;
//    the frame resumes when it deasserts. A HDR word already committed is still emitted.
//  - enable dropped mid-packet: the current frame completes normally; no new HDR starts.
//  - pkt_words change mid-packet: no effect until the next HDR.
//  - tx_overflow: tx_overrun_cnt += 1 each cycle it is high, in any state, saturating at
//    all-ones. Framing is unaffected.
//  - Back-to-back frames: IDLE->HDR costs one cycle. The minimum inter-frame gap is 1 idle cycle.
// TESTING
//  1. pkt_words=4, continuous in_valid, data 1..8 -> two frames of HDR+4 words. EOF on words 4 and 8.
//     Header seq = 0 then 1. pkt_cnt=2.
//  2. pkt_words=0, MAX_WORDS=100 -> 100 payload words; EOF on the 100th word. pkt_words=200
//     -> clamped to 100.
//  3. Send 3 words, then in_valid=0 for TIMEOUT cycles -> pad word 64'hFFFF_FFFF_FFFF_FFFF
//     with EOF, busy->0.
//  4. tx_afull=1 for 10 cycles mid-PAY -> in_ready=0 and no tx_valid for those cycles.
//     The timeout does not fire. The frame resumes with the correct count.
//  5. tx_overflow high for 5 cycles -> tx_overrun_cnt=5. Preload near all-ones -> it stays
//     at 32'hFFFF_FFFF.
//  6. user_rst pulsed mid-PAY -> all outputs 0 on the next cycle. The next frame header has seq=0.

Source files
------------

// File: rtl/gbe64_tx_packet_ctrl.sv
// gbe64_tx_packet_ctrl
// Frames the photon word stream for the 64-bit 10GbE TX core. Each frame is one
// header word {seq, ts}, then up to L payload words, with EOF on the last word.
// A partial packet is flushed with an all-ones pad word after TIMEOUT idle cycles.
// New accepts stop while the TX core reports almost-full.
// Overflow cycles from the TX core are counted with saturation.
module gbe64_tx_packet_ctrl #(
    parameter int DATA_W    = 64,
    parameter int MAX_WORDS = 100,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 32
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              enable,
    input  logic [7:0]        pkt_words,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_end_of_frame,
    input  logic              tx_afull,
    input  logic              tx_overflow,
    output logic [CNT_W-1:0]  tx_overrun_cnt,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              busy
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);
    localparam int         TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  seq_reg, seq_next;
    logic [CNT_W-1:0]  pkt_cnt_reg, pkt_cnt_next;
    logic [CNT_W-1:0]  ts_reg;
    logic [CNT_W-1:0]  overrun_reg;
    logic [7:0]        len_reg, len_next;
    logic [7:0]        wcnt_reg, wcnt_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic              tx_valid_reg, tx_valid_next;
    logic              tx_eof_reg, tx_eof_next;

    logic [7:0]        eff_len;
    logic [DATA_W-1:0] header_word;
    logic              accept;
    logic              idle_slot;

    // Zero and oversize lengths both select the maximum payload length.
    assign eff_len     = ((pkt_words == 8'd0) || (pkt_words > MAX_LEN)) ? MAX_LEN : pkt_words;
    assign header_word = DATA_W'({32'(seq_reg), 32'(ts_reg)});

    assign in_ready  = (state_reg == PAY) && !tx_afull;
    assign accept    = in_ready && in_valid;
    assign idle_slot = in_ready && !in_valid;

    assign tx_data         = tx_data_reg;
    assign tx_valid        = tx_valid_reg;
    assign tx_end_of_frame = tx_eof_reg;
    assign tx_overrun_cnt  = overrun_reg;
    assign pkt_cnt         = pkt_cnt_reg;
    assign busy            = (state_reg != IDLE);

    // Free-running timestamp stamped into every header.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    // Overflow cycle counter, sticks at all-ones so software sees saturation.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            overrun_reg <= '0;
        end else if (tx_overflow && (overrun_reg != {CNT_W{1'b1}})) begin
            overrun_reg <= overrun_reg + 1'b1;
        end
    end

    // Framing state and registered TX outputs.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_reg    <= IDLE;
            seq_reg      <= '0;
            pkt_cnt_reg  <= '0;
            len_reg      <= 8'd0;
            wcnt_reg     <= 8'd0;
            to_cnt_reg   <= '0;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            tx_eof_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            seq_reg      <= seq_next;
            pkt_cnt_reg  <= pkt_cnt_next;
            len_reg      <= len_next;
            wcnt_reg     <= wcnt_next;
            to_cnt_reg   <= to_cnt_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            tx_eof_reg   <= tx_eof_next;
        end
    end

    // Next-state and next-output logic; an accepted word always beats the timeout.
    always_comb begin
        state_next    = state_reg;
        seq_next      = seq_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        len_next      = len_reg;
        wcnt_next     = wcnt_reg;
        to_cnt_next   = to_cnt_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = 1'b0;
        tx_eof_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable && in_valid && !tx_afull) begin
                    state_next = HDR;
                end
            end

            HDR: begin
                // The header is committed here even if almost-full rises now.
                tx_data_next  = header_word;
                tx_valid_next = 1'b1;
                len_next      = eff_len;
                seq_next      = seq_reg + 1'b1;
                wcnt_next     = 8'd0;
                to_cnt_next   = '0;
                state_next    = PAY;
            end

            PAY: begin
                if (accept) begin
                    tx_data_next  = in_data;
                    tx_valid_next = 1'b1;
                    to_cnt_next   = '0;
                    if (wcnt_reg == (len_reg - 8'd1)) begin
                        tx_eof_next  = 1'b1;
                        pkt_cnt_next = pkt_cnt_reg + 1'b1;
                        state_next   = IDLE;
                    end else begin
                        wcnt_next = wcnt_reg + 8'd1;
                    end
                end else if (idle_slot) begin
                    if (to_cnt_reg == TO_LAST) begin
                        tx_data_next  = {DATA_W{1'b1}};
                        tx_valid_next = 1'b1;
                        tx_eof_next   = 1'b1;
                        pkt_cnt_next  = pkt_cnt_reg + 1'b1;
                        state_next    = IDLE;
                    end else begin
                        to_cnt_next = to_cnt_reg + 1'b1;
                    end
                end
                // While almost-full the timeout counter simply holds.
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gbe64_tx_packet_ctrl.sv
// Testbench for gbe64_tx_packet_ctrl: random payload data pushed through the
// valid/ready handshake, output stream captured and compared against frames
// built from the accepted words and the framing rules.
`timescale 1ns/1ps
module tb_gbe64_tx_packet_ctrl;

    localparam int TO = 20;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic        enable;
    logic [7:0]  pkt_words;
    logic [63:0] in_data;
    logic        in_valid;
    logic        tx_afull;
    logic        tx_overflow;
    wire         in_ready;
    wire  [63:0] tx_data;
    wire         tx_valid;
    wire         tx_end_of_frame;
    wire  [31:0] tx_overrun_cnt;
    wire  [31:0] pkt_cnt;
    wire         busy;

    wire         s_in_ready;
    wire  [63:0] s_tx_data;
    wire         s_tx_valid;
    wire         s_tx_eof;
    wire  [3:0]  s_overrun;
    wire  [3:0]  s_pkt_cnt;
    wire         s_busy;

    always #5 user_clk = ~user_clk;

    gbe64_tx_packet_ctrl #(.DATA_W(64), .MAX_WORDS(100), .TIMEOUT(TO), .CNT_W(32)) u_dut (
        .user_clk        (user_clk),
        .user_rst        (user_rst),
        .enable          (enable),
        .pkt_words       (pkt_words),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_end_of_frame (tx_end_of_frame),
        .tx_afull        (tx_afull),
        .tx_overflow     (tx_overflow),
        .tx_overrun_cnt  (tx_overrun_cnt),
        .pkt_cnt         (pkt_cnt),
        .busy            (busy)
    );

    // Narrow-counter instance used only to reach overrun saturation quickly.
    gbe64_tx_packet_ctrl #(.DATA_W(64), .MAX_WORDS(100), .TIMEOUT(TO), .CNT_W(4)) u_sat (
        .user_clk        (user_clk),
        .user_rst        (user_rst),
        .enable          (1'b0),
        .pkt_words       (8'd0),
        .in_data         (64'd0),
        .in_valid        (1'b0),
        .in_ready        (s_in_ready),
        .tx_data         (s_tx_data),
        .tx_valid        (s_tx_valid),
        .tx_end_of_frame (s_tx_eof),
        .tx_afull        (1'b0),
        .tx_overflow     (tx_overflow),
        .tx_overrun_cnt  (s_overrun),
        .pkt_cnt         (s_pkt_cnt),
        .busy            (s_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    int exp_seq;
    int exp_pkts;
    int ovf_total;
    bit last_acc;

    logic [63:0] mon_data[$];
    bit          mon_eof[$];
    int          mon_cyc[$];
    logic [63:0] acc_data[$];
    int          acc_cyc[$];

    // Cycles since reset; equals the expected timestamp.
    always @(posedge user_clk) begin
        if (user_rst) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Capture every valid TX word with the cycle it appeared in.
    always @(negedge user_clk) begin
        if (tx_valid === 1'b1) begin
            mon_data.push_back(tx_data);
            mon_eof.push_back(tx_end_of_frame);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: note handshake/overflow before the edge, return #1 after it.
    task automatic cycle();
        @(negedge user_clk);
        last_acc = 1'b0;
        if (in_valid && in_ready) begin
            acc_data.push_back(in_data);
            acc_cyc.push_back(cyc);
            last_acc = 1'b1;
        end
        if (tx_overflow) ovf_total++;
        @(posedge user_clk);
        #1;
    endtask

    task automatic push_words(input int n, input int max_gap);
        int g;
        int t;
        for (int k = 0; k < n; k++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                cycle();
            end
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            t = 0;
            do begin
                cycle();
                t++;
            end while (!last_acc && t < 300);
            chk("accept_wait", 64'(last_acc), 64'd1);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy !== 1'b0 || tx_valid !== 1'b0); i++) cycle();
        chk("idle_wait", 64'(busy), 64'd0);
    endtask

    // Pop one frame from the capture and check it against the accepted words.
    task automatic check_frame(input int npay, input bit pad, output int hdr_cyc, output int eof_cyc);
        int need;
        logic [63:0] d;
        logic [63:0] ad;
        bit e;
        int c;
        int ac;
        need = 1 + npay + (pad ? 1 : 0);
        hdr_cyc = 0;
        eof_cyc = 0;
        ac = 0;
        for (int i = 0; i < 50 && mon_data.size() < need; i++) cycle();
        chk("frame_size", 64'(mon_data.size() >= need), 64'd1);
        if (mon_data.size() < need || acc_data.size() < npay) return;
        d = mon_data.pop_front(); e = mon_eof.pop_front(); c = mon_cyc.pop_front();
        hdr_cyc = c;
        chk("hdr_seq", 64'(d[63:32]), 64'(exp_seq));
        chk("hdr_ts", 64'(d[31:0]), 64'(32'(c - 1)));
        chk("hdr_eof", 64'(e), 64'd0);
        for (int i = 0; i < npay; i++) begin
            d = mon_data.pop_front(); e = mon_eof.pop_front(); c = mon_cyc.pop_front();
            ad = acc_data.pop_front(); ac = acc_cyc.pop_front();
            chk("pay_data", d, ad);
            chk("pay_eof", 64'(e), 64'((!pad) && (i == npay - 1)));
            chk("pay_latency", 64'(c), 64'(ac + 1));
            eof_cyc = c;
        end
        if (pad) begin
            d = mon_data.pop_front(); e = mon_eof.pop_front(); c = mon_cyc.pop_front();
            chk("pad_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("pad_eof", 64'(e), 64'd1);
            chk("pad_time", 64'(c), 64'(ac + TO + 1));
            eof_cyc = c;
        end
        exp_seq++;
        exp_pkts++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_eof"}, 64'(tx_end_of_frame), 64'd0);
        chk({tag, "_tx_data"}, tx_data, 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_overrun"}, 64'(tx_overrun_cnt), 64'd0);
        chk({tag, "_sat_overrun"}, 64'(s_overrun), 64'd0);
    endtask

    initial begin
        int h1, e1, h2, e2;
        int n;
        user_rst    = 1'b1;
        enable      = 1'b0;
        pkt_words   = 8'd4;
        in_data     = 64'd0;
        in_valid    = 1'b0;
        tx_afull    = 1'b0;
        tx_overflow = 1'b0;
        exp_seq = 0; exp_pkts = 0; ovf_total = 0;

        // Reset state
        repeat (3) cycle();
        chk_reset_outputs("reset");
        user_rst = 1'b0;
        enable   = 1'b1;
        cycle();

        // Two back-to-back 4-word frames from a continuous stream
        pkt_words = 8'd4;
        push_words(8, 0);
        in_valid = 1'b0;
        wait_idle();
        check_frame(4, 1'b0, h1, e1);
        check_frame(4, 1'b0, h2, e2);
        chk("ifg", 64'(h2 - e1), 64'd2);
        chk("pkt_cnt_t1", 64'(pkt_cnt), 64'(exp_pkts));

        // Length 0 selects MAX_WORDS
        pkt_words = 8'd0;
        push_words(100, 2);
        in_valid = 1'b0;
        wait_idle();
        check_frame(100, 1'b0, h1, e1);

        // Length 200 clamps to 100; mid-frame length change and enable drop are ignored
        pkt_words = 8'd200;
        push_words(50, 2);
        pkt_words = 8'd3;
        enable    = 1'b0;
        push_words(50, 2);
        in_valid = 1'b0;
        wait_idle();
        check_frame(100, 1'b0, h1, e1);
        chk("pkt_cnt_t2", 64'(pkt_cnt), 64'(exp_pkts));
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("disabled_busy", 64'(busy), 64'd0);
            chk("disabled_ready", 64'(in_ready), 64'd0);
            chk("disabled_valid", 64'(tx_valid), 64'd0);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        cycle();

        // Partial packet flushed by timeout
        pkt_words = 8'd10;
        push_words(3, 1);
        in_valid = 1'b0;
        wait_idle();
        check_frame(3, 1'b1, h1, e1);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("pkt_cnt_t3", 64'(pkt_cnt), 64'(exp_pkts));

        // Almost-full: blocks start in IDLE, header still emitted, PAY throttled
        pkt_words = 8'd8;
        tx_afull  = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("afull_idle_busy", 64'(busy), 64'd0);
            chk("afull_idle_valid", 64'(tx_valid), 64'd0);
        end
        tx_afull = 1'b0;
        cycle();
        chk("hdr_busy", 64'(busy), 64'd1);
        chk("hdr_ready", 64'(in_ready), 64'd0);
        tx_afull = 1'b1;
        repeat (3) begin
            cycle();
            chk("afull_hdr_ready", 64'(in_ready), 64'd0);
        end
        tx_afull = 1'b0;
        push_words(3, 0);
        in_valid = 1'b0;
        repeat (15) cycle();
        for (int i = 0; i < 10; i++) begin
            tx_afull = 1'b1;
            #1;
            chk("afull_ready", 64'(in_ready), 64'd0);
            chk("afull_valid", 64'(tx_valid), 64'd0);
            cycle();
        end
        tx_afull = 1'b0;
        push_words(5, 0);
        in_valid = 1'b0;
        wait_idle();
        check_frame(8, 1'b0, h1, e1);
        chk("pkt_cnt_t4", 64'(pkt_cnt), 64'(exp_pkts));

        // Overflow counting and saturation
        tx_overflow = 1'b1;
        repeat (5) cycle();
        tx_overflow = 1'b0;
        cycle();
        chk("overrun_5", 64'(tx_overrun_cnt), 64'd5);
        n = $urandom_range(20, 12);
        tx_overflow = 1'b1;
        repeat (n) cycle();
        tx_overflow = 1'b0;
        cycle();
        chk("overrun_total", 64'(tx_overrun_cnt), 64'(ovf_total));
        chk("overrun_sat", 64'(s_overrun), 64'((ovf_total > 15) ? 15 : ovf_total));
        chk("framing_idle", 64'(busy), 64'd0);

        // Reset mid-PAY abandons the frame and restarts sequencing
        pkt_words = 8'd6;
        push_words(3, 0);
        in_valid = 1'b0;
        user_rst = 1'b1;
        cycle();
        chk_reset_outputs("midrst");
        user_rst = 1'b0;
        mon_data.delete(); mon_eof.delete(); mon_cyc.delete();
        acc_data.delete(); acc_cyc.delete();
        exp_seq = 0; exp_pkts = 0; ovf_total = 0;
        cycle();
        pkt_words = 8'd2;
        push_words(2, 1);
        in_valid = 1'b0;
        wait_idle();
        check_frame(2, 1'b0, h1, e1);
        chk("pkt_cnt_t6", 64'(pkt_cnt), 64'(exp_pkts));
        chk("leftover_words", 64'(mon_data.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
